// File: rtl/magphase_pkg.sv
// Shared constants and helpers for the CORDIC magnitude/phase consumer.
// Phase values are signed radians scaled by 2^28, magnitudes are Q.14.
// wrap_phase folds a raw phase difference back into (-pi, pi].
package magphase_pkg;

    localparam int PHASE_FRAC_BITS = 28;
    localparam int MAG_FRAC_BITS   = 14;

    localparam logic signed [63:0] PI_Q28     = 64'sd843314857;
    localparam logic signed [63:0] TWO_PI_Q28 = 64'sd1686629713;

    // Exactly -pi maps to +pi (minus one LSB, since 2*pi is odd here),
    // so the result interval is half-open at the negative end.
    function automatic logic signed [63:0] wrap_phase(input logic signed [63:0] raw);
        if (raw > PI_Q28) begin
            return raw - TWO_PI_Q28;
        end else if (raw <= -PI_Q28) begin
            return raw + TWO_PI_Q28;
        end else begin
            return raw;
        end
    endfunction

endpackage

// File: rtl/magphase_result_fifo.sv
// Synchronous FIFO holding packed tracker results.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   clr          synchronous flush (wins over push/pop)
//   push/wr_data write request; accepted when not full or when popping
//   pop          read request; ignored when empty
//   rd_data      head entry (register contents, stable until pop)
//   level        occupancy, full, empty
// DEPTH must be a power of two so the pointers wrap naturally.
module magphase_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A push into a full FIFO still succeeds if the head leaves this cycle.
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/magphase_phase_tracker.sv
// Phase tracker behind the CORDIC magnitude/phase engine.
// For each engine result it produces the wrapped phase difference to the
// previous sample and a running unwrapped phase, then queues the result in
// a small FIFO because the engine cannot be stalled.
// Ports:
//   clk, rst, clr            clock, async active-high reset, sync clear
//   in_valid/in_magnitude/in_phase   one result per CORDIC done pulse
//   out_valid/out_ready      FIFO head handshake
//   out_dphase, out_phase_unwrapped, out_magnitude, out_first   head entry
//   drop_count               saturating count of samples lost to a full FIFO
//   fifo_level               FIFO occupancy
//   squelch_count            (SQUELCH_MAG_EN only) saturating count of
//                            samples discarded for magnitude < MAG_THRESH
// Build option: define SQUELCH_MAG_EN to enable the low-magnitude squelch.
module magphase_phase_tracker
    import magphase_pkg::*;
#(
    parameter int INT_WIDTH    = 32,
    parameter int UNWRAP_WIDTH = 40,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAG_THRESH   = 164
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          in_valid,
    input  logic [INT_WIDTH-1:0]          in_magnitude,
    input  logic [INT_WIDTH-1:0]          in_phase,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INT_WIDTH-1:0]          out_dphase,
    output logic [UNWRAP_WIDTH-1:0]       out_phase_unwrapped,
    output logic [INT_WIDTH-1:0]          out_magnitude,
    output logic                          out_first,
    output logic [15:0]                   drop_count,
`ifdef SQUELCH_MAG_EN
    output logic [15:0]                   squelch_count,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int ENTRY_W = 1 + 2*INT_WIDTH + UNWRAP_WIDTH;
    localparam int EXT_W   = UNWRAP_WIDTH - INT_WIDTH;

    logic                    have_prev_q, have_prev_d;
    logic [INT_WIDTH-1:0]    prev_phase_q, prev_phase_d;

    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_first_q, s1_first_d;
    logic [INT_WIDTH-1:0]    s1_mag_q, s1_mag_d;
    logic [INT_WIDTH-1:0]    s1_phase_q, s1_phase_d;
    logic [INT_WIDTH:0]      s1_raw_q, s1_raw_d;

    logic                    s2_valid_q, s2_valid_d;
    logic                    s2_first_q, s2_first_d;
    logic [INT_WIDTH-1:0]    s2_mag_q, s2_mag_d;
    logic [INT_WIDTH-1:0]    s2_dphase_q, s2_dphase_d;

    logic [UNWRAP_WIDTH-1:0] acc_q, acc_d;
    logic [15:0]             drop_count_q, drop_count_d;

    logic                    take;
    logic                    pop;
    logic                    drop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [INT_WIDTH-1:0]    dphase_w;
    logic [ENTRY_W-1:0]      wr_entry;
    logic [ENTRY_W-1:0]      rd_entry;

`ifdef SQUELCH_MAG_EN
    localparam logic signed [INT_WIDTH-1:0] MAG_THRESH_S = INT_WIDTH'(MAG_THRESH);
    logic                    squelched;
    logic [15:0]             squelch_count_q, squelch_count_d;
`endif

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    // Entry lost only when full and nothing leaves in the same cycle.
    assign drop      = s2_valid_q && fifo_full && !pop;
    assign wr_entry  = {s2_first_q, s2_mag_q, s2_dphase_q, acc_q};

    assign {out_first, out_magnitude, out_dphase, out_phase_unwrapped} = rd_entry;
    assign drop_count = drop_count_q;

    // Stage 1 captures the sample and its raw difference; stage 2 wraps it
    // and updates the accumulator, whose value travels into the FIFO with
    // the stage-2 registers on the following edge.
    always_comb begin
`ifdef SQUELCH_MAG_EN
        squelched       = in_valid && !clr && ($signed(in_magnitude) < MAG_THRESH_S);
        take            = in_valid && !clr && !squelched;
        squelch_count_d = squelch_count_q;
        if (clr) begin
            squelch_count_d = '0;
        end else if (squelched && squelch_count_q != 16'hFFFF) begin
            squelch_count_d = squelch_count_q + 1'b1;
        end
`else
        take = in_valid && !clr;
`endif

        have_prev_d  = have_prev_q;
        prev_phase_d = prev_phase_q;
        s1_valid_d   = take;
        s1_first_d   = s1_first_q;
        s1_mag_d     = s1_mag_q;
        s1_phase_d   = s1_phase_q;
        s1_raw_d     = s1_raw_q;
        if (take) begin
            s1_first_d   = !have_prev_q;
            s1_mag_d     = in_magnitude;
            s1_phase_d   = in_phase;
            s1_raw_d     = {in_phase[INT_WIDTH-1], in_phase}
                         - {prev_phase_q[INT_WIDTH-1], prev_phase_q};
            have_prev_d  = 1'b1;
            prev_phase_d = in_phase;
        end

        dphase_w = s1_first_q ? '0 :
            INT_WIDTH'(wrap_phase({{(63-INT_WIDTH){s1_raw_q[INT_WIDTH]}}, s1_raw_q}));

        s2_valid_d  = s1_valid_q;
        s2_first_d  = s2_first_q;
        s2_mag_d    = s2_mag_q;
        s2_dphase_d = s2_dphase_q;
        acc_d       = acc_q;
        if (s1_valid_q) begin
            s2_first_d  = s1_first_q;
            s2_mag_d    = s1_mag_q;
            s2_dphase_d = dphase_w;
            if (s1_first_q) begin
                acc_d = {{EXT_W{s1_phase_q[INT_WIDTH-1]}}, s1_phase_q};
            end else begin
                acc_d = acc_q + {{EXT_W{dphase_w[INT_WIDTH-1]}}, dphase_w};
            end
        end

        drop_count_d = drop_count_q;
        if (drop && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 1'b1;
        end

        if (clr) begin
            have_prev_d  = 1'b0;
            s1_valid_d   = 1'b0;
            s2_valid_d   = 1'b0;
            acc_d        = '0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_prev_q  <= 1'b0;
            prev_phase_q <= '0;
            s1_valid_q   <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_mag_q     <= '0;
            s1_phase_q   <= '0;
            s1_raw_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_first_q   <= 1'b0;
            s2_mag_q     <= '0;
            s2_dphase_q  <= '0;
            acc_q        <= '0;
            drop_count_q <= '0;
        end else begin
            have_prev_q  <= have_prev_d;
            prev_phase_q <= prev_phase_d;
            s1_valid_q   <= s1_valid_d;
            s1_first_q   <= s1_first_d;
            s1_mag_q     <= s1_mag_d;
            s1_phase_q   <= s1_phase_d;
            s1_raw_q     <= s1_raw_d;
            s2_valid_q   <= s2_valid_d;
            s2_first_q   <= s2_first_d;
            s2_mag_q     <= s2_mag_d;
            s2_dphase_q  <= s2_dphase_d;
            acc_q        <= acc_d;
            drop_count_q <= drop_count_d;
        end
    end

`ifdef SQUELCH_MAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            squelch_count_q <= '0;
        end else begin
            squelch_count_q <= squelch_count_d;
        end
    end

    assign squelch_count = squelch_count_q;
`endif

    magphase_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .push    (s2_valid_q && !clr),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_magphase_phase_tracker.sv
// Directed bench for magphase_phase_tracker: a vector table for the phase
// arithmetic plus hand-written sequences for latency, overflow, clear and
// reset behaviour.
module tb_magphase_phase_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic [31:0] in_magnitude;
    logic [31:0] in_phase;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_dphase;
    logic [39:0] out_phase_unwrapped;
    logic [31:0] out_magnitude;
    logic        out_first;
    logic [15:0] drop_count;
    logic [2:0]  fifo_level;
`ifdef SQUELCH_MAG_EN
    logic [15:0] squelch_count;
`endif

    always #5 clk = ~clk;

    magphase_phase_tracker dut (
        .clk                 (clk),
        .rst                 (rst),
        .clr                 (clr),
        .in_valid            (in_valid),
        .in_magnitude        (in_magnitude),
        .in_phase            (in_phase),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_dphase          (out_dphase),
        .out_phase_unwrapped (out_phase_unwrapped),
        .out_magnitude       (out_magnitude),
        .out_first           (out_first),
        .drop_count          (drop_count),
`ifdef SQUELCH_MAG_EN
        .squelch_count       (squelch_count),
`endif
        .fifo_level          (fifo_level)
    );

    typedef struct {
        logic [31:0] phase;
        logic [31:0] mag;
        logic        first;
        logic [31:0] dphase;
        logic [39:0] unwrap;
    } vec_t;

    typedef struct {
        logic        first;
        logic [31:0] mag;
        logic [31:0] dphase;
        logic [39:0] unwrap;
    } ent_t;

    ent_t captured[$];
    int   checks   = 0;
    int   failures = 0;

    // Drive one cycle of inputs at the falling edge; just before the next
    // rising edge, record the head entry if it is about to be popped.
    task automatic applyStimulus(input logic v, input logic [31:0] ph,
                                 input logic [31:0] mg, input logic rdy,
                                 input logic c);
        ent_t e;
        @(negedge clk);
        in_valid     = v;
        in_phase     = ph;
        in_magnitude = mg;
        out_ready    = rdy;
        clr          = c;
        #1;
        if (out_valid && out_ready) begin
            e.first  = out_first;
            e.mag    = out_magnitude;
            e.dphase = out_dphase;
            e.unwrap = out_phase_unwrapped;
            captured.push_back(e);
        end
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 32'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic checkEntry(input string name, input int idx, input logic first,
                              input logic [31:0] mag, input logic [31:0] dphase,
                              input logic [39:0] unwrap);
        if (idx >= captured.size()) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s[%0d] missing entry, captured=%0d", name, idx, captured.size());
        end else begin
            checkOutput($sformatf("%s[%0d]", name, idx),
                        {captured[idx].first, captured[idx].mag, captured[idx].dphase, captured[idx].unwrap},
                        {first, mag, dphase, unwrap});
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{32'sd210828714,  32'd16384, 1'b1, 32'sd0,          40'd210828714};
        vecs[1] = '{32'sd632486143,  32'd8192,  1'b0, 32'sd421657429,  40'd632486143};
        vecs[2] = '{-32'sd632486143, 32'd200,   1'b0, 32'sd421657427,  40'd1054143570};
        vecs[3] = '{32'sd632486143,  32'd20000, 1'b0, -32'sd421657427, 40'd632486143};
        vecs[4] = '{32'sd0,          32'd16384, 1'b0, -32'sd632486143, 40'd0};
        vecs[5] = '{-32'sd843314857, 32'd164,   1'b0, 32'sd843314856,  40'd843314856};
        vecs[6] = '{32'sd0,          32'd5000,  1'b0, 32'sd843314857,  40'd1686629713};

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_phase = '0;
        in_magnitude = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    {out_valid, fifo_level, drop_count, out_first, out_dphase, out_phase_unwrapped, out_magnitude},
                    '0);
        rst = 1'b0;

        // Latency: pulse before edge N, out_valid first high after N+2.
        applyStimulus(1'b1, 32'd12345, 32'd16384, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("latency_after_N", out_valid, 1'b0);
        idle(1'b0);
        checkOutput("latency_after_N1", out_valid, 1'b0);
        idle(1'b0);
        checkOutput("latency_after_N2", {out_valid, fifo_level}, {1'b1, 3'd1});

        // Phase arithmetic table, back-to-back samples with the consumer ready.
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        captured.delete();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, vecs[i].phase, vecs[i].mag, 1'b1, 1'b0);
        end
        repeat (5) idle(1'b1);
        checkOutput("table_count", captured.size(), 7);
        for (int i = 0; i < 7; i++) begin
            checkEntry("table", i, vecs[i].first, vecs[i].mag, vecs[i].dphase, vecs[i].unwrap);
        end

        // Overflow: six samples into a 4-deep FIFO with the consumer stalled.
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        captured.delete();
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 32'(i * 1000), 32'd16384, 1'b0, 1'b0);
        end
        repeat (3) idle(1'b0);
        checkOutput("overflow_level_drops", {fifo_level, drop_count}, {3'd4, 16'd2});

        // Full FIFO: push and pop land on the same edge.
        applyStimulus(1'b1, 32'd7000, 32'd16384, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        checkOutput("full_push_pop", {fifo_level, drop_count}, {3'd4, 16'd2});
        repeat (6) idle(1'b1);
        checkOutput("drain_count", captured.size(), 5);
        checkEntry("drain", 0, 1'b1, 32'd16384, 32'd0,    40'd1000);
        checkEntry("drain", 1, 1'b0, 32'd16384, 32'd1000, 40'd2000);
        checkEntry("drain", 2, 1'b0, 32'd16384, 32'd1000, 40'd3000);
        checkEntry("drain", 3, 1'b0, 32'd16384, 32'd1000, 40'd4000);
        checkEntry("drain", 4, 1'b0, 32'd16384, 32'd1000, 40'd7000);

        // Clear with a sample in flight and another on the clearing edge.
        captured.delete();
        applyStimulus(1'b1, 32'd1234, 32'd16384, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd100000000, 32'd16384, 1'b0, 1'b1);
        repeat (3) idle(1'b0);
        checkOutput("clr_flush", {out_valid, fifo_level, drop_count}, {1'b0, 3'd0, 16'd0});
        applyStimulus(1'b1, 32'd5000, 32'd16384, 1'b1, 1'b0);
        repeat (4) idle(1'b1);
        checkOutput("clr_next_count", captured.size(), 1);
        checkEntry("clr_next", 0, 1'b1, 32'd16384, 32'd0, 40'd5000);

        // Low-magnitude sample between two normal ones.
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        captured.delete();
        applyStimulus(1'b1, 32'd1000, 32'd16384, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'd2000, 32'd100,   1'b1, 1'b0);
        applyStimulus(1'b1, 32'd4000, 32'd16384, 1'b1, 1'b0);
        repeat (5) idle(1'b1);
`ifdef SQUELCH_MAG_EN
        checkOutput("squelch_count", squelch_count, 16'd1);
        checkOutput("squelch_entries", captured.size(), 2);
        checkEntry("squelch", 0, 1'b1, 32'd16384, 32'd0,    40'd1000);
        checkEntry("squelch", 1, 1'b0, 32'd16384, 32'd3000, 40'd4000);
`else
        checkOutput("lowmag_entries", captured.size(), 3);
        checkEntry("lowmag", 0, 1'b1, 32'd16384, 32'd0,    40'd1000);
        checkEntry("lowmag", 1, 1'b0, 32'd100,   32'd1000, 40'd2000);
        checkEntry("lowmag", 2, 1'b0, 32'd16384, 32'd2000, 40'd4000);
`endif

        // Asynchronous reset with data queued.
        applyStimulus(1'b1, 32'd10, 32'd16384, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd20, 32'd16384, 1'b0, 1'b0);
        repeat (3) idle(1'b0);
        checkOutput("pre_rst_level", fifo_level, 3'd2);
        rst = 1'b1;
        #1;
        checkOutput("async_rst",
                    {out_valid, fifo_level, out_first, out_dphase, out_phase_unwrapped, out_magnitude},
                    '0);
        @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
